// File: rtl/divider_if.sv
// Execute-stage divide port: request, operands and mode in; stall and result out.
interface divider_if;
  logic        divE;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        div_stall;
  logic [63:0] s;

  modport master (
    output divE, is_signed, a, b,
    input  div_stall, s
  );

  modport slave (
    input  divE, is_signed, a, b,
    output div_stall, s
  );
endinterface

// File: rtl/divider.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// s[63:32] = remainder, s[31:0] = quotient; stalls the pipeline for 34 cycles.
//
// state | meaning
// IDLE  | waiting for divE; operands latched on start
// RUN   | 32 restoring steps, MSB first
// FIX   | sign correction, result loaded into s
// DONE  | one-cycle hold so a still-high divE does not restart
module divider (
  input  logic     clk,
  input  logic     reset,
  divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [32:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [31:0] r_a;
  logic [4:0]  r_cnt;
  logic        r_signed;
  logic        r_qneg;
  logic        r_rneg;
  logic [63:0] r_s;

  logic        w_start;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign w_start = bus.divE & (r_state == IDLE) & ~reset;

  assign w_a_mag = (bus.is_signed & bus.a[31]) ? -bus.a : bus.a;
  assign w_b_mag = (bus.is_signed & bus.b[31]) ? -bus.b : bus.b;

  // Partial remainder stays below the divisor, so 33 bits hold the shifted value.
  assign w_shift = {r_rem[31:0], r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift - {1'b0, r_dvs};

  assign w_q_fix = (r_signed & r_qneg) ? -r_quo : r_quo;
  assign w_r_fix = (r_signed & r_rneg) ? -r_rem[31:0] : r_rem[31:0];

  assign bus.s = r_s;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = RUN;
      RUN:     if (r_cnt == 5'd31) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.div_stall = ~reset & (w_start | (r_state == RUN) | (r_state == FIX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_a      <= '0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_s      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_quo    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_a      <= bus.a;
            r_signed <= bus.is_signed;
            r_qneg   <= bus.a[31] ^ bus.b[31];
            r_rneg   <= bus.a[31];
            r_rem    <= '0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_rem <= w_ge ? w_diff : w_shift;
          r_quo <= {r_quo[30:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
        end
        FIX: begin
          // Zero divisor: |b| is zero exactly when b is zero, in either mode.
          if (r_dvs == 32'd0) r_s <= {r_a, 32'hFFFF_FFFF};
          else                r_s <= {w_r_fix, w_q_fix};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for divider: stall length, result, DONE/IDLE behaviour, reset abort.
module tb_divider;

  logic clk;
  logic reset;
  divider_if bus ();

  divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Counts consecutive stall cycles starting at the current (start) cycle.
  task automatic wait_done(input bit scramble, output int n);
    n = 0;
    while (bus.div_stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      if (scramble) begin
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.is_signed = 1'($urandom_range(0, 1));
      end
      #1;
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int n;
    @(negedge clk);
    bus.a         = v.a;
    bus.b         = v.b;
    bus.is_signed = v.sg;
    bus.divE      = 1'b1;
    #1;
    wait_done(1'b1, n);
    chk($sformatf("v%0d stall_len", id), 64'(n), 64'd34);
    chk($sformatf("v%0d result", id), bus.s, v.exp);
    chk($sformatf("v%0d done_stall", id), 64'(bus.div_stall), 64'd0);
    bus.divE = 1'b0;
    @(negedge clk);
    #1;
    chk($sformatf("v%0d idle_stall", id), 64'(bus.div_stall), 64'd0);
    chk($sformatf("v%0d s_hold", id), bus.s, v.exp);
  endtask

  initial begin
    int n;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, {32'd2,         32'd14}};
    vecs[1]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vecs[2]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, {32'd1,         32'hFFFF_FFFD}};
    vecs[3]  = '{32'hFFFF_FFFF, 32'd1,         1'b0, {32'd0,         32'hFFFF_FFFF}};
    vecs[4]  = '{32'hFFFF_FFFF, 32'd1,         1'b1, {32'd0,         32'hFFFF_FFFF}};
    vecs[5]  = '{32'h1234_5678, 32'd0,         1'b0, {32'h1234_5678, 32'hFFFF_FFFF}};
    vecs[6]  = '{32'h1234_5678, 32'd0,         1'b1, {32'h1234_5678, 32'hFFFF_FFFF}};
    vecs[7]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0,         32'h8000_0000}};
    vecs[8]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'd0}};
    vecs[9]  = '{32'hFFFF_FF9C, 32'd7,         1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}};
    vecs[10] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'h0000_000E}};
    vecs[11] = '{32'hFFFF_FFFF, 32'h10,        1'b0, {32'h0000_000F, 32'h0FFF_FFFF}};

    // Reset held with divE high: reset must win over start.
    reset         = 1'b1;
    bus.divE      = 1'b1;
    bus.a         = 32'd50;
    bus.b         = 32'd5;
    bus.is_signed = 1'b0;
    #1;
    chk("rst_stall0", 64'(bus.div_stall), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall1", 64'(bus.div_stall), 64'd0);
    chk("rst_s", bus.s, 64'd0);
    bus.divE = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_idle", 64'(bus.div_stall), 64'd0);
    chk("post_rst_s", bus.s, 64'd0);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset at RUN cycle 10 aborts; s must clear, not take a partial result.
    @(negedge clk);
    bus.a         = 32'd1000;
    bus.b         = 32'd3;
    bus.is_signed = 1'b0;
    bus.divE      = 1'b1;
    #1;
    chk("abort_start_stall", 64'(bus.div_stall), 64'd1);
    repeat (11) @(negedge clk);
    #1;
    chk("abort_run_stall", 64'(bus.div_stall), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_rst_stall", 64'(bus.div_stall), 64'd0);
    @(negedge clk);
    #1;
    chk("abort_s_cleared", bus.s, 64'd0);
    chk("abort_idle_stall", 64'(bus.div_stall), 64'd0);
    reset = 1'b0;
    #1;
    chk("restart_stall", 64'(bus.div_stall), 64'd1);
    wait_done(1'b0, n);
    chk("restart_len", 64'(n), 64'd34);
    chk("restart_result", bus.s, {32'd1, 32'd333});
    bus.divE = 1'b0;
    @(negedge clk);
    #1;
    chk("restart_idle", 64'(bus.div_stall), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32-bit operands and a 64-bit result.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 divE  input  1  divide request from the Execute stage, held high until the pipeline advances.
REQ-005 is_signed  input  1  1 selects two's-complement division, 0 selects unsigned; sampled at start only.
REQ-006 a  input  32  dividend; sampled at start only.
REQ-007 b  input  32  divisor; sampled at start only.
REQ-008 div_stall  output  1  combinational pipeline stall request.
REQ-009 s  output  64  registered result: s[63:32] = remainder (HI), s[31:0] = quotient (LO).

Function
REQ-010 States SHALL be IDLE, RUN, FIX and DONE; start SHALL be defined as divE & (state==IDLE) & ~reset.
REQ-011 The IDLE->RUN transition SHALL occur on start; at that edge the block SHALL latch |a|, |b| (magnitudes when is_signed, raw values otherwise), is_signed, the quotient sign a[31]^b[31] and the remainder sign a[31], and SHALL clear the 33-bit partial remainder and the 5-bit iteration counter.
REQ-012 RUN SHALL perform one restoring step per cycle, MSB first: shift {rem, dividend} left by 1, trial-subtract the divisor, set the quotient bit to 1 and keep the difference if it is non-negative, otherwise set the bit to 0 and restore.
REQ-013 RUN SHALL last exactly 32 cycles (counter 0..31) and SHALL then transition to FIX.
REQ-014 FIX SHALL last one cycle; at its closing edge s SHALL be loaded with the sign-corrected result and the state SHALL become DONE.
REQ-015 Sign correction SHALL apply only when is_signed: the quotient is negated when the quotient sign is 1 and the remainder is negated when the remainder sign is 1; the remainder SHALL take the sign of the dividend.
REQ-016 DONE SHALL last one cycle and then transition to IDLE, so that a divE still held high during the advancing cycle does not restart the block.
REQ-017 div_stall SHALL equal start | (state==RUN) | (state==FIX), i.e. high for exactly 34 consecutive cycles per divide and low in DONE.
REQ-018 When b==0, s SHALL be {a, 32'hFFFFFFFF} regardless of is_signed, with identical latency.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-020 Changes on a, b, is_signed or divE after start SHALL NOT affect an operation in progress.
REQ-021 s SHALL hold its value until the next FIX completes or reset is applied.

Reset
REQ-022 On a clock edge with reset high: state SHALL become IDLE; s, the counter and all working registers SHALL become 0.
REQ-023 While reset is high, div_stall SHALL be 0; reset in any state, including mid-RUN, SHALL abort the operation without updating s to a partial result.
REQ-024 reset SHALL take priority over start at the same edge.

Verification
REQ-025 Unsigned case: a=100, b=7, is_signed=0, divE held -> div_stall high for 34 cycles, then s = {32'd2, 32'd14}; div_stall low in DONE; no restart in the following IDLE cycle if divE has dropped.
REQ-026 Signed case: a=-7 (0xFFFFFFF9), b=2 -> s = {32'hFFFFFFFF, 32'hFFFFFFFD}; with a=7, b=-2 -> s = {32'd1, 32'hFFFFFFFD}.
REQ-027 Same operands, both modes: a=0xFFFFFFFF, b=1 -> unsigned s = {0, 0xFFFFFFFF}; signed s = {0, 0xFFFFFFFF}.
REQ-028 Divide by zero: a=0x12345678, b=0, either mode -> s = {0x12345678, 0xFFFFFFFF} after the normal 34-cycle stall.
REQ-029 Signed overflow: a=0x80000000, b=0xFFFFFFFF -> s = {0, 0x80000000}.
REQ-030 Reset mid-operation: reset pulsed at RUN cycle 10 -> next cycle IDLE, div_stall=0, s=0; divE held high afterwards -> a fresh 34-cycle divide with a correct result.
